mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multicycle signed MULT/DIV engine feeding the CPU's HI and LO registers.
//  The control unit pulses start with an opcode, then holds its FSM until done.
//  When done is high, the control unit asserts the HI/LO write enable.
//  MULT uses radix-2 Booth, one iteration per clock.
//  DIV uses restoring division on magnitudes with sign fix-up, one iteration per clock.
//  DIV0 is reported to the control unit for exception handling (vector 253/254/255 path).
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//  clk     in   1      system clock, rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      request; sampled only in IDLE
//  op      in   1      0 = MULT, 1 = DIV; sampled with start
//  a       in   WIDTH  MULT multiplicand / DIV dividend (A register), signed
//  b       in   WIDTH  MULT multiplier / DIV divisor (B register), signed
//  hi      out  WIDTH  MULT: product[63:32]; DIV: remainder
//  lo      out  WIDTH  MULT: product[31:0];  DIV: quotient
//  busy    out  1      high in MULT_RUN and DIV_RUN
//  done    out  1      high for exactly one cycle in state DONE
//  div0    out  1      divide-by-zero flag
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous, active-high.
//  Reset: state=IDLE; hi=lo=0; busy=done=div0=0; iteration counter=0.
//   Reset applies mid-operation and aborts it; no partial result is kept.
//  States: IDLE, MULT_RUN, DIV_RUN, DONE.
//  IDLE, start=1 at edge E0:
//   - operands latched into internal regs; counter cleared; div0 cleared.
//   - op=0: next state MULT_RUN.
//   - op=1, b!=0: next state DIV_RUN.
//   - op=1, b==0: next state DONE; div0=1; hi/lo unchanged.
//  RUN: each edge performs one iteration. After WIDTH iterations (edge E0+WIDTH):
//   - hi/lo updated in the same edge; state -> DONE.
//   - done is high in cycle E0+WIDTH..E0+WIDTH+1; next edge -> IDLE.
//   - Total latency start -> done = WIDTH+1 edges (33 at default). Div0 latency = 1 edge.
//  start while busy or in DONE: ignored, not queued. op/a/b changes while running: no effect.
//  hi/lo change only on completion of a run (or reset); they are held otherwise.
//  div0 holds until the next accepted start.
//  MULT: exact signed 2*WIDTH product. 0x80000000*0x80000000 = 0x4000000000000000.
//  DIV: quotient truncates toward zero; remainder takes the sign of the dividend (MIPS).
//   Edge case: -2^31 / -1 -> lo=0x80000000, hi=0 (wraps); no overflow flag.
//  Internal working registers: 2*WIDTH+1 bits for Booth (product + Q-1).
//   Counter is $clog2(WIDTH)+1 bits; counter wrap is not permitted.
// TESTING
//  1. MULT a=7, b=-3 -> done 33 cycles after start edge; hi=FFFFFFFF, lo=FFFFFFEB, div0=0.
//  2. DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV a=7, b=-2 -> lo=FFFFFFFD, hi=00000001.
//  3. Preload hi/lo via MULT 5*5, then DIV b=0 -> done and div0 in the cycle after start;
//     hi=0, lo=25 unchanged.
//  4. MULT 80000000*80000000 -> hi=40000000, lo=0; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  5. Assert reset at iteration 10 of a MULT -> all outputs 0 next edge;
//     new MULT 3*4 -> lo=12 in 33 cycles.
//  6. Pulse start with different operands during busy and during DONE -> ignored;
//     first result intact; exactly one done pulse.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the CPU control unit and the MULT/DIV engine.
// Latency: none, this only carries wires.
// Backpressure: none; the master issues start only while busy/done are low.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div0
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div0
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring, magnitude + sign fix-up) into HI/LO.
// Latency: WIDTH+1 edges from the accepted start edge to done; divide-by-zero reports after 1 edge.
// Backpressure: start is honoured only in IDLE; starts while busy or done are dropped, never queued.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             state_q;
  // MULT: {A, Q, Q-1}.  DIV: {R (WIDTH+1 bits), Q}.
  logic [2*WIDTH:0]   acc_q;
  // MULT: multiplicand.  DIV: divisor magnitude.
  logic [WIDTH-1:0]   m_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               div0_q;

  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   booth_d;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH:0]   div_d;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;

  // One Booth step and one restoring-division step, plus operand magnitudes and final sign fix-up.
  always_comb begin
    // A is sign-extended by one bit so that subtracting the most negative multiplicand cannot overflow.
    booth_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    case (acc_q[1:0])
      2'b01:   booth_sum = booth_sum + {m_q[WIDTH-1], m_q};
      2'b10:   booth_sum = booth_sum - {m_q[WIDTH-1], m_q};
      default: booth_sum = booth_sum;
    endcase
    // Arithmetic shift right of {A, Q, Q-1}; the extra sum bit supplies the true sign.
    booth_d = {booth_sum, acc_q[WIDTH:1]};

    // Shift {R, Q} left by one, then try subtracting the divisor from R.
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, m_q};
    if (!div_trial[WIDTH]) begin
      div_d = {div_trial, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_d = {div_shift, acc_q[WIDTH-2:0], 1'b0};
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quo_res = neg_quo_q ? -div_d[WIDTH-1:0]       : div_d[WIDTH-1:0];
    rem_res = neg_rem_q ? -div_d[2*WIDTH-1:WIDTH] : div_d[2*WIDTH-1:WIDTH];

    // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1) correctly.
    a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
    b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
  end

  // Control FSM with registered outputs; reset aborts any run and discards partial state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            cnt_q  <= '0;
            div0_q <= 1'b0;
            if (!bus.op) begin
              acc_q   <= {{WIDTH{1'b0}}, bus.b, 1'b0};
              m_q     <= bus.a;
              busy_q  <= 1'b1;
              state_q <= MULT_RUN;
            end else if (bus.b != '0) begin
              acc_q     <= {{(WIDTH+1){1'b0}}, a_mag};
              m_q       <= b_mag;
              neg_quo_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              neg_rem_q <= bus.a[WIDTH-1];
              busy_q    <= 1'b1;
              state_q   <= DIV_RUN;
            end else begin
              // Divide by zero: report immediately, HI/LO keep their old contents.
              div0_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        MULT_RUN: begin
          acc_q <= booth_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            hi_q    <= booth_d[2*WIDTH:WIDTH+1];
            lo_q    <= booth_d[WIDTH:1];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DIV_RUN: begin
          acc_q <= div_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            hi_q    <= rem_res;
            lo_q    <= quo_res;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          // DONE: single-cycle done pulse, any start here is dropped.
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases with literal results plus randomized operations,
// with a cycle-by-cycle comparison of every output against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact signed product, truncating division, remainder with dividend sign.
  function automatic void ref_calc(input bit op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
    longint sa;
    longint sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op) begin
      p  = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rh = r[31:0];
      rl = q[31:0];
    end
  endfunction

  // Reference model: a result appears WIDTH edges after an accepted start, done lasts one cycle.
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  logic        m_busy, m_done, m_div0;
  int          m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_div0 = 0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = r_hi; m_lo = r_lo; m_busy = 0; m_done = 1;
      end
    end else if (bus.start) begin
      m_div0 = 0;
      if (bus.op && bus.b == '0) begin
        m_div0 = 1;
        m_done = 1;
      end else begin
        ref_calc(bus.op, bus.a, bus.b, r_hi, r_lo);
        m_left = W;
        m_busy = 1;
      end
    end
  end

  // Compare every output against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_hi",   {32'h0, bus.hi},   {32'h0, m_hi});
      chk("cyc_lo",   {32'h0, bus.lo},   {32'h0, m_lo});
      chk("cyc_busy", {63'h0, bus.busy}, {63'h0, m_busy});
      chk("cyc_done", {63'h0, bus.done}, {63'h0, m_done});
      chk("cyc_div0", {63'h0, bus.div0}, {63'h0, m_div0});
    end
  end

  // Issue one operation from IDLE; returns edges from the start edge (inclusive) to done visible.
  task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b, output int edges);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
    edges = 1;
    while (!bus.done && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    if (!bus.done) chk("done_timeout", 64'(edges), 64'(W + 1));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int   edges;
    int   dcount;
    bit   op;
    logic [31:0] a, b;

    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_hi",   {32'h0, bus.hi},   64'h0);
    chk("rst_lo",   {32'h0, bus.lo},   64'h0);
    chk("rst_busy", {63'h0, bus.busy}, 64'h0);
    chk("rst_done", {63'h0, bus.done}, 64'h0);
    chk("rst_div0", {63'h0, bus.div0}, 64'h0);
    reset = 1'b0;

    // 7 * -3
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, edges);
    chk("mul7_lat", 64'(edges), 64'd33);
    chk("mul7_hi",  {32'h0, bus.hi}, 64'hFFFF_FFFF);
    chk("mul7_lo",  {32'h0, bus.lo}, 64'hFFFF_FFEB);
    chk("mul7_d0",  {63'h0, bus.div0}, 64'h0);

    // -7 / 2 and 7 / -2
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, edges);
    chk("divn7_lat", 64'(edges), 64'd33);
    chk("divn7_lo", {32'h0, bus.lo}, 64'hFFFF_FFFD);
    chk("divn7_hi", {32'h0, bus.hi}, 64'hFFFF_FFFF);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, edges);
    chk("div7n_lo", {32'h0, bus.lo}, 64'hFFFF_FFFD);
    chk("div7n_hi", {32'h0, bus.hi}, 64'h0000_0001);

    // 5*5 then divide by zero: HI/LO retained
    run_op(1'b0, 32'd5, 32'd5, edges);
    run_op(1'b1, 32'd99, 32'd0, edges);
    chk("div0_lat", 64'(edges), 64'd1);
    chk("div0_flag", {63'h0, bus.div0}, 64'h1);
    chk("div0_hi", {32'h0, bus.hi}, 64'h0);
    chk("div0_lo", {32'h0, bus.lo}, 64'd25);
    repeat (3) @(negedge clk);
    chk("div0_hold", {63'h0, bus.div0}, 64'h1);

    // Most-negative corners
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, edges);
    chk("mulmin_hi", {32'h0, bus.hi}, 64'h4000_0000);
    chk("mulmin_lo", {32'h0, bus.lo}, 64'h0);
    chk("mulmin_d0", {63'h0, bus.div0}, 64'h0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges);
    chk("divmin_lo", {32'h0, bus.lo}, 64'h8000_0000);
    chk("divmin_hi", {32'h0, bus.hi}, 64'h0);

    // Reset during iteration 10 of a MULT
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd123457; bus.b = 32'hFFFF_FF9D;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_hi",   {32'h0, bus.hi},   64'h0);
    chk("abort_lo",   {32'h0, bus.lo},   64'h0);
    chk("abort_busy", {63'h0, bus.busy}, 64'h0);
    chk("abort_done", {63'h0, bus.done}, 64'h0);
    reset = 1'b0;
    run_op(1'b0, 32'd3, 32'd4, edges);
    chk("mul34_lat", 64'(edges), 64'd33);
    chk("mul34_lo", {32'h0, bus.lo}, 64'd12);
    chk("mul34_hi", {32'h0, bus.hi}, 64'h0);

    // Starts during busy and during DONE are ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd6; bus.b = 32'd7;
    dcount = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
      bus.start = (i == 5) || bus.done;
      bus.op = 1'b1; bus.a = 32'd100; bus.b = 32'd3;
    end
    bus.start = 1'b0;
    chk("ign_dcount", 64'(dcount), 64'd1);
    chk("ign_lo", {32'h0, bus.lo}, 64'd42);
    chk("ign_hi", {32'h0, bus.hi}, 64'h0);

    // Randomized operations; results checked cycle-by-cycle against the model
    for (int n = 0; n < 40; n++) begin
      op = 1'($urandom);
      a  = pick();
      b  = pick();
      run_op(op, a, b, edges);
      chk("rnd_lat", 64'(edges), (op && b == '0) ? 64'd1 : 64'd33);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
